// File: rtl/g729_dbg_pkg.sv
// Shared types and constants for the G.729 encoder stage-dump reader.
package g729_dbg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DONE,
    HDR,
    WAIT_RD,
    SEND,
    RELEASE
  } state_t;

  localparam logic [7:0] HDR_SYNC = 8'hA5;
  localparam int NUM_STAGES_DEF = 9;

  function automatic logic [31:0] hdr_word(
    input logic [3:0]  idx,
    input logic [11:0] len
  );
    return {HDR_SYNC, 4'h0, idx, 4'h0, len};
  endfunction

endpackage

// File: rtl/g729_edge_det.sv
// Rising-edge detector for level strobes such as done/ready.
module g729_edge_det (
  input  logic clock,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sig_q <= 1'b0;
    else       sig_q <= sig;
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/g729_stage_reader.sv
// Host-side stage reader: waits for encoder done, dumps a buffer
// window as header + data words, then releases the encoder.
module g729_stage_reader
  import g729_dbg_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int NUM_STAGES = NUM_STAGES_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              host_start,
  input  logic [ADDR_W-1:0] dump_base,
  input  logic [ADDR_W-1:0] dump_len,
  input  logic              done,
  input  logic [DATA_W-1:0] out,
  output logic              start,
  output logic [ADDR_W-1:0] outBufAddr,
  output logic              testdone,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [3:0]        stage_idx,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  state_t state, state_n;

  logic              done_rise;
  logic              take;
  logic              last_stage;
  logic [ADDR_W-1:0] len;
  logic [ADDR_W-1:0] cnt;
  logic [1:0]        lat;
  logic [DATA_W-1:0] data_r;

  g729_edge_det u_done_edge (
    .clock (clock),
    .reset (reset),
    .sig   (done),
    .rise  (done_rise)
  );

  assign take       = (state == IDLE) && host_start;
  assign last_stage = (stage_idx == 4'(NUM_STAGES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:      if (host_start) state_n = WAIT_DONE;
      WAIT_DONE: if (done_rise)  state_n = HDR;
      HDR:
        if (m_ready)
          state_n = (len == '0) ? RELEASE : WAIT_RD;
      WAIT_RD:   if (lat == 2'd1) state_n = SEND;
      SEND:
        if (m_ready)
          state_n = (cnt + ADDR_W'(1) == len) ? RELEASE : WAIT_RD;
      RELEASE:   state_n = last_stage ? IDLE : WAIT_DONE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      start      <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      stage_idx  <= '0;
      outBufAddr <= '0;
      len        <= '0;
      cnt        <= '0;
      lat        <= '0;
      data_r     <= '0;
    end else begin
      start      <= take;
      frame_done <= 1'b0;
      if (take) begin
        stage_idx <= '0;
        overrun   <= 1'b0;
      end
      // Edges outside WAIT_DONE are dropped but remembered.
      if (done_rise && state != WAIT_DONE) overrun <= 1'b1;
      case (state)
        WAIT_DONE:
          if (done_rise) begin
            len        <= dump_len;
            outBufAddr <= dump_base;
            cnt        <= '0;
          end
        HDR:
          if (m_ready) lat <= 2'(RD_LAT);
        WAIT_RD:
          if (lat == 2'd1) data_r <= out;
          else             lat    <= lat - 2'd1;
        SEND:
          if (m_ready) begin
            cnt        <= cnt + ADDR_W'(1);
            outBufAddr <= outBufAddr + ADDR_W'(1);
            lat        <= 2'(RD_LAT);
          end
        RELEASE: begin
          stage_idx <= stage_idx + 4'd1;
          if (last_stage) frame_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign m_valid  = (state == HDR) || (state == SEND);
  assign m_data   = (state == HDR) ? DATA_W'(hdr_word(stage_idx, 12'(len)))
                                   : data_r;
  assign testdone = (state == RELEASE);
  assign busy     = (state != IDLE);

endmodule
